booth_operand_sequencer: RTL and testbench

Upstream/downstream companion to the 16-bit signed Booth multiplier datapath. It accepts a (multiplicand, multiplier) pair on a valid/ready handshake and serialises it onto the multiplier's shared data_in bus: multiplicand first with start, then multiplier. It then waits for the multiplier's done, captures the 32-bit {A,Q} result and presents it downstream on a valid/ready handshake. A watchdog flags a multiplier that never signals done.

---
 rtl/booth_pkg.sv | 17 +
 rtl/booth_watchdog.sv | 29 ++
 rtl/booth_operand_sequencer.sv | 120 ++++++++++++
 tb/tb_booth_operand_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types and defaults for the Booth multiplier operand sequencer.
// The product is the multiplier's {A,Q} pair, so it is twice the operand width.
package booth_pkg;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 40;
  localparam int PRODUCT_WIDTH   = 2 * DEFAULT_WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_M = 3'd1,
    LOAD_Q = 3'd2,
    WAIT   = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/booth_watchdog.sv
// Clear/enable cycle counter that raises tc when it reaches TIMEOUT-1.
// The owner leaves the counting state on tc, so the count never wraps.
module booth_watchdog
  import booth_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign tc = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/booth_operand_sequencer.sv
// Serialises an operand pair onto the Booth multiplier's shared data_in bus,
// waits for done (guarded by a watchdog) and presents the product downstream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The input side only offers ready in IDLE; once out_valid is raised the
// product and error flag stay frozen until out_ready completes the transfer.
module booth_operand_sequencer
  import booth_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_mcand,
  input  logic [WIDTH-1:0]   in_mplier,
  output logic [WIDTH-1:0]   mult_data_in,
  output logic               mult_start,
  input  logic               mult_done,
  input  logic [2*WIDTH-1:0] mult_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               out_error,
  output logic               busy,
  output state_t             dbg_state
);

  state_t           state;
  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_tc;

  assign wd_clr = (state == LOAD_Q);
  assign wd_en  = (state == WAIT);

  booth_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk(clk),
    .rst(rst),
    .clr(wd_clr),
    .en (wd_en),
    .tc (wd_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mcand_r     <= '0;
      mplier_r    <= '0;
      in_ready    <= 1'b1;
      mult_start  <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand_r    <= in_mcand;
            mplier_r   <= in_mplier;
            in_ready   <= 1'b0;
            mult_start <= 1'b1;
            state      <= LOAD_M;
          end
        end
        LOAD_M: begin
          mult_start <= 1'b0;
          state      <= LOAD_Q;
        end
        LOAD_Q: begin
          state <= WAIT;
        end
        WAIT: begin
          // A done on the terminal watchdog cycle still delivers the real product.
          if (mult_done) begin
            out_product <= mult_result;
            out_error   <= 1'b0;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end else if (wd_tc) begin
            out_product <= '0;
            out_error   <= 1'b1;
            out_valid   <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // The bus carries the multiplicand only in LOAD_M, then holds the multiplier.
  always_comb begin
    mult_data_in = '0;
    case (state)
      LOAD_M:             mult_data_in = mcand_r;
      LOAD_Q, WAIT, HOLD: mult_data_in = mplier_r;
      default:            mult_data_in = '0;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Directed bench for booth_operand_sequencer with a behavioural Booth multiplier
// model and hand-computed expected products.
module tb_booth_operand_sequencer;
  import booth_pkg::*;

  localparam int W       = 16;
  localparam int TIMEOUT = 40;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [W-1:0]    in_mcand = '0;
  logic [W-1:0]    in_mplier = '0;
  logic [W-1:0]    mult_data_in;
  logic            mult_start;
  logic            mult_done;
  logic [2*W-1:0]  mult_result;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [2*W-1:0]  out_product;
  logic            out_error;
  logic            busy;
  state_t          dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  booth_operand_sequencer #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier),
    .mult_data_in(mult_data_in), .mult_start(mult_start),
    .mult_done(mult_done), .mult_result(mult_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_error(out_error),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- multiplier model ----------------
  // Captures M on the start cycle, Q on the next, then pulses done for one cycle
  // model_delay+1 cycles into WAIT. model_en=0 models a hung multiplier.
  int           model_delay = 34;
  bit           model_en = 1'b1;
  logic         force_done = 1'b0;
  logic         model_done;
  logic [W-1:0] m_reg, q_reg;
  logic         q_pending;
  int           cd;

  function automatic logic [2*W-1:0] mul_model(logic [W-1:0] a, logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      model_done  <= 1'b0;
      mult_result <= '0;
      q_pending   <= 1'b0;
      cd          <= 0;
    end else begin
      model_done <= 1'b0;
      if (mult_start) begin
        m_reg     <= mult_data_in;
        q_pending <= 1'b1;
      end else if (q_pending) begin
        q_reg     <= mult_data_in;
        q_pending <= 1'b0;
        cd        <= model_en ? model_delay : 0;
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          model_done  <= 1'b1;
          mult_result <= mul_model(m_reg, q_reg);
        end
      end
    end
  end

  assign mult_done = model_done | force_done;

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Accepts the pair, checks the LOAD_M/LOAD_Q bus sequence, returns in WAIT cycle 1.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit spurious);
    check("in_ready_idle", in_ready, 1);
    in_valid  = 1'b1;
    in_mcand  = a;
    in_mplier = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    force_done = spurious;
    check("load_m_start", mult_start, 1);
    check("load_m_data", mult_data_in, a);
    check("load_m_in_ready", in_ready, 0);
    @(negedge clk);
    check("load_q_start", mult_start, 0);
    check("load_q_data", mult_data_in, b);
    @(negedge clk);
    force_done = 1'b0;
    check("wait_state", dbg_state, WAIT);
    check("wait_no_valid", out_valid, 0);
    check("wait_data", mult_data_in, b);
  endtask

  task automatic wait_valid(input int exp_cycles);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("valid_latency", n, exp_cycles);
    check("hold_state", dbg_state, HOLD);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input bit exp_e, input int exp_n);
    start_op(a, b, 1'b0);
    wait_valid(exp_n);
    check("product", out_product, exp_p);
    check("error", out_error, exp_e);
    release_out();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [2*W-1:0] held_p;
    do_reset();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_product", out_product, 0);
    check("rst_out_error", out_error, 0);
    check("rst_start", mult_start, 0);
    check("rst_data", mult_data_in, 0);
    check("rst_busy", busy, 0);

    // Done pulses 35 cycles into WAIT with model_delay=34.
    run_op(16'h0003, 16'hFFFB, 32'hFFFF_FFF1, 1'b0, 35);
    run_op(16'h8000, 16'h8000, 32'h4000_0000, 1'b0, 35);
    run_op(16'h0000, 16'h04D2, 32'h0000_0000, 1'b0, 35);
    model_delay = 5;
    run_op(16'h0064, 16'hFF38, 32'hFFFF_B1E0, 1'b0, 6);

    // Downstream back-pressure with ignored input pulses.
    start_op(16'h0011, 16'h0002, 1'b0);
    wait_valid(6);
    check("bp_product", out_product, 32'h0000_0022);
    held_p = out_product;
    for (int i = 0; i < 10; i++) begin
      in_valid  = i[0];
      in_mcand  = 16'($urandom_range(0, 16'hFFFF));
      in_mplier = 16'($urandom_range(0, 16'hFFFF));
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_product_stable", out_product, held_p);
      check("bp_error", out_error, 0);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();
    check("bp_idle", dbg_state, IDLE);

    // Hung multiplier: timeout exactly TIMEOUT cycles into WAIT.
    model_en = 1'b0;
    run_op(16'h0005, 16'h0007, 32'h0, 1'b1, TIMEOUT);
    model_en = 1'b1;

    // Done on the terminal watchdog cycle beats the timeout.
    model_delay = TIMEOUT - 1;
    run_op(16'h0064, 16'h00C8, 32'h0000_4E20, 1'b0, TIMEOUT);
    model_delay = 5;

    // Reset while in WAIT.
    start_op(16'h0009, 16'h0009, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_valid", out_valid, 0);
    check("rstw_busy", busy, 0);
    check("rstw_in_ready", in_ready, 1);
    run_op(16'h0007, 16'h0006, 32'h0000_002A, 1'b0, 6);

    // Reset while in HOLD discards the product.
    start_op(16'h0009, 16'h0009, 1'b0);
    wait_valid(6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rsth_valid", out_valid, 0);
    check("rsth_busy", busy, 0);
    check("rsth_product", out_product, 0);
    run_op(16'h0007, 16'h0006, 32'h0000_002A, 1'b0, 6);

    // Spurious done during LOAD_M/LOAD_Q is ignored.
    start_op(16'hFFFE, 16'h0003, 1'b1);
    wait_valid(6);
    check("spur_product", out_product, 32'hFFFF_FFFA);
    check("spur_error", out_error, 0);
    release_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
